// File: rtl/bus_arb_if.sv
// Domain-side and memory-side signals of the byte-bus arbiter.
// master: the arbiter's view; slave: the domains plus memory.
interface bus_arb_if #(
  parameter int NUM_DOMAINS = 2
);
  logic [NUM_DOMAINS-1:0]      dom_req;
  logic [NUM_DOMAINS-1:0]      dom_we;
  logic [17*NUM_DOMAINS-1:0]   dom_addr;
  logic [8*NUM_DOMAINS-1:0]    dom_wdata;
  logic [NUM_DOMAINS-1:0]      dom_gnt;
  logic [NUM_DOMAINS-1:0]      dom_ack;
  logic [7:0]                  dom_rdata;
  logic                        dom_err;
  logic                        mem_req;
  logic                        mem_we;
  logic [16:0]                 mem_addr;
  logic [7:0]                  mem_wdata;
  logic                        mem_ack;
  logic [7:0]                  mem_rdata;

  modport master (
    input  dom_req, dom_we, dom_addr, dom_wdata, mem_ack, mem_rdata,
    output dom_gnt, dom_ack, dom_rdata, dom_err,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output dom_req, dom_we, dom_addr, dom_wdata, mem_ack, mem_rdata,
    input  dom_gnt, dom_ack, dom_rdata, dom_err,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/bus_arb.sv
// Round-robin arbiter of NUM_DOMAINS byte requesters onto one req/ack memory port.
// Optional BUS_ARB_TIMEOUT_EN aborts an ISSUE after TIMEOUT_CYCLES with rdata=FF, err=1.
module bus_arb #(
  parameter int NUM_DOMAINS    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic      clk,
  input  logic      reset,
  bus_arb_if.master bus
);
  localparam int PTR_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_DOMAINS - 1);

  if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("bus_arb: unsupported NUM_DOMAINS/TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t                 state, n_state;
  logic [PTR_W-1:0]       ptr, n_ptr, owner, n_owner, sel;
  logic                   found, tmo;
  logic [NUM_DOMAINS-1:0] gnt, n_gnt, ack, n_ack;
  logic [7:0]             rdata, n_rdata, mwdata, n_mwdata;
  logic                   err, n_err, mreq, n_mreq, mwe, n_mwe;
  logic [16:0]            maddr, n_maddr;

  // First requester strictly after the last owner, wrapping.
  always_comb begin : p_sel
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= NUM_DOMAINS; k++) begin
      idx = (int'(ptr) + k) % NUM_DOMAINS;
      if (!found && bus.dom_req[idx]) begin
        found = 1'b1;
        sel   = PTR_W'(idx);
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt;

  // Held at zero outside ISSUE so it restarts on every entry.
  always_ff @(posedge clk) begin
    if (reset || state != ISSUE) cnt <= '0;
    else if (!bus.mem_ack)       cnt <= cnt + 1'b1;
  end

  assign tmo = (state == ISSUE) && !bus.mem_ack && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= PTR_RST;
      owner  <= '0;
      gnt    <= '0;
      ack    <= '0;
      rdata  <= '0;
      err    <= 1'b0;
      mreq   <= 1'b0;
      mwe    <= 1'b0;
      maddr  <= '0;
      mwdata <= '0;
    end else begin
      state  <= n_state;
      ptr    <= n_ptr;
      owner  <= n_owner;
      gnt    <= n_gnt;
      ack    <= n_ack;
      rdata  <= n_rdata;
      err    <= n_err;
      mreq   <= n_mreq;
      mwe    <= n_mwe;
      maddr  <= n_maddr;
      mwdata <= n_mwdata;
    end
  end

  always_comb begin
    n_state = state;
    case (state)
      IDLE:    if (found) n_state = ISSUE;
      ISSUE:   if (bus.mem_ack || tmo) n_state = DONE;
      DONE:    n_state = IDLE;
      default: n_state = IDLE;
    endcase
  end

  always_comb begin
    n_ptr    = ptr;
    n_owner  = owner;
    n_gnt    = gnt;
    n_ack    = '0;
    n_rdata  = rdata;
    n_err    = err;
    n_mreq   = mreq;
    n_mwe    = mwe;
    n_maddr  = maddr;
    n_mwdata = mwdata;
    case (state)
      IDLE: if (found) begin
        n_owner  = sel;
        n_gnt    = NUM_DOMAINS'(1) << sel;
        n_mreq   = 1'b1;
        n_mwe    = bus.dom_we[sel];
        n_maddr  = bus.dom_addr[int'(sel)*17 +: 17];
        n_mwdata = bus.dom_wdata[int'(sel)*8 +: 8];
      end
      // A same-cycle ack beats the timeout.
      ISSUE: if (bus.mem_ack) begin
        n_rdata = bus.mem_rdata;
        n_ack   = NUM_DOMAINS'(1) << owner;
        n_err   = 1'b0;
        n_mreq  = 1'b0;
      end else if (tmo) begin
        n_rdata = 8'hFF;
        n_ack   = NUM_DOMAINS'(1) << owner;
        n_err   = 1'b1;
        n_mreq  = 1'b0;
      end
      DONE: begin
        n_gnt = '0;
        n_err = 1'b0;
        n_ptr = owner;
      end
      default: ;
    endcase
  end

  assign bus.dom_gnt   = gnt;
  assign bus.dom_ack   = ack;
  assign bus.dom_rdata = rdata;
  assign bus.dom_err   = err;
  assign bus.mem_req   = mreq;
  assign bus.mem_we    = mwe;
  assign bus.mem_addr  = maddr;
  assign bus.mem_wdata = mwdata;
endmodule

// File: tb/tb_bus_arb.sv
// Bench for bus_arb: vector table plus hand sequences; acks checked against a scoreboard queue.
module tb_bus_arb;
  localparam int N = 2;

  typedef struct {
    int          dom;
    logic        we;
    logic [16:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          waits;
  } vec_t;

  typedef struct {
    logic [N-1:0] ack;
    logic [7:0]   rdata;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   mon_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t e;
  vec_t vecs[5];

  bus_arb_if #(.NUM_DOMAINS(N)) bus ();

  bus_arb #(.NUM_DOMAINS(N), .TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every ack pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mon_en && bus.dom_ack !== '0) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: got %b expected none", bus.dom_ack);
      end else begin
        e = sb.pop_front();
        chk("ack", bus.dom_ack, e.ack);
        chk("rdata", bus.dom_rdata, e.rdata);
        chk("err", bus.dom_err, e.err);
      end
    end
  end

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      got = bus.mem_req;
    end
    chk("grant_seen", got, 1);
  endtask

  task automatic run_txn(input vec_t v, input bit drop);
    bit got;
    bus.dom_we[v.dom]              = v.we;
    bus.dom_addr[v.dom*17 +: 17]   = v.addr;
    bus.dom_wdata[v.dom*8 +: 8]    = v.wdata;
    bus.dom_req[v.dom]             = 1'b1;
    wait_req(got);
    if (!got) begin
      bus.dom_req = '0;
      return;
    end
    chk("gnt", bus.dom_gnt, 1 << v.dom);
    chk("mem_we", bus.mem_we, v.we);
    chk("mem_addr", bus.mem_addr, v.addr);
    chk("mem_wdata", bus.mem_wdata, v.wdata);
    if (drop) begin
      bus.dom_req[v.dom]           = 1'b0;
      bus.dom_we[v.dom]            = ~v.we;
      bus.dom_addr[v.dom*17 +: 17] = ~v.addr;
      bus.dom_wdata[v.dom*8 +: 8]  = ~v.wdata;
    end
    for (int w = 0; w < v.waits; w++) begin
      @(negedge clk);
      chk("hold_req", bus.mem_req, 1);
      chk("hold_we", bus.mem_we, v.we);
      chk("hold_addr", bus.mem_addr, v.addr);
      chk("hold_wdata", bus.mem_wdata, v.wdata);
    end
    sb.push_back('{ack: N'(1) << v.dom, rdata: v.rdata, err: 1'b0});
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = v.rdata;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    chk("req_drop", bus.mem_req, 0);
    bus.dom_req[v.dom] = 1'b0;
  endtask

  initial begin
    bit got;
    vecs[0] = '{dom: 0, we: 1'b0, addr: 17'h1_2345, wdata: 8'h00, rdata: 8'hA5, waits: 0};
    vecs[1] = '{dom: 1, we: 1'b1, addr: 17'h0_0010, wdata: 8'h3C, rdata: 8'h11, waits: 3};
    vecs[2] = '{dom: 0, we: 1'b1, addr: 17'h1_FFFF, wdata: 8'hFF, rdata: 8'h00, waits: 1};
    vecs[3] = '{dom: 1, we: 1'b0, addr: 17'h0_ABCD, wdata: 8'h81, rdata: 8'h5A, waits: 2};
    vecs[4] = '{dom: 1, we: 1'b0, addr: 17'h0_0000, wdata: 8'h00, rdata: 8'hC3, waits: 0};

    bus.dom_req   = '0;
    bus.dom_we    = '0;
    bus.dom_addr  = '0;
    bus.dom_wdata = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_gnt", bus.dom_gnt, 0);
    chk("rst_ack", bus.dom_ack, 0);
    chk("rst_rdata", bus.dom_rdata, 0);
    chk("rst_err", bus.dom_err, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    foreach (vecs[i]) run_txn(vecs[i], 1'b0);

    // Requester withdraws and scrambles its inputs mid-transaction.
    run_txn('{dom: 0, we: 1'b0, addr: 17'h0_1111, wdata: 8'h00, rdata: 8'h77, waits: 2}, 1'b1);

    // Stray mem_ack while idle.
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'hEE;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    @(negedge clk);
    chk("idle_ack", bus.dom_ack, 0);
    chk("idle_mem_req", bus.mem_req, 0);
    chk("rdata_held", bus.dom_rdata, 8'h77);

    // Contention straight out of reset.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.dom_addr[16:0]  = 17'h0_0AAA;
    bus.dom_addr[33:17] = 17'h1_5555;
    bus.dom_we          = 2'b00;
    bus.dom_req         = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_req(got);
      chk("rr_gnt", bus.dom_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("rr_addr", bus.mem_addr, (k % 2 == 0) ? 17'h0_0AAA : 17'h1_5555);
      sb.push_back('{ack: (k % 2 == 0) ? 2'b01 : 2'b10, rdata: 8'h10 + 8'(k), err: 1'b0});
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 8'h10 + 8'(k);
      @(negedge clk);
      bus.mem_ack   = 1'b0;
    end
    bus.dom_req = '0;

    // Reset in ISSUE: domain 1 wins after domain 0, reset aborts, domain 0 wins again.
    run_txn('{dom: 0, we: 1'b0, addr: 17'h0_0042, wdata: 8'h00, rdata: 8'h42, waits: 0}, 1'b0);
    bus.dom_req = 2'b11;
    wait_req(got);
    chk("pre_rst_gnt", bus.dom_gnt, 2'b10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_mem_req", bus.mem_req, 0);
    chk("abort_gnt", bus.dom_gnt, 0);
    chk("abort_ack", bus.dom_ack, 0);
    wait_req(got);
    chk("post_rst_gnt", bus.dom_gnt, 2'b01);
    sb.push_back('{ack: 2'b01, rdata: 8'h99, err: 1'b0});
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 8'h99;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.dom_req   = '0;

`ifdef BUS_ARB_TIMEOUT_EN
    bus.dom_we[1]        = 1'b0;
    bus.dom_addr[33:17]  = 17'h0_0BAD;
    bus.dom_req[1]       = 1'b1;
    wait_req(got);
    chk("tmo_gnt", bus.dom_gnt, 2'b10);
    sb.push_back('{ack: 2'b10, rdata: 8'hFF, err: 1'b1});
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk("tmo_hold_req", bus.mem_req, 1);
    end
    @(negedge clk);
    chk("tmo_req_drop", bus.mem_req, 0);
    bus.dom_req = '0;
    run_txn('{dom: 0, we: 1'b0, addr: 17'h0_0C0C, wdata: 8'h00, rdata: 8'h5C, waits: 3}, 1'b0);
`else
    run_txn('{dom: 1, we: 1'b0, addr: 17'h1_0101, wdata: 8'h00, rdata: 8'h3E, waits: 10}, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
